// File: rtl/tick_pkg.sv
// Shared types and helpers for the tick prescaler time base.
// Used by tick_prescaler and btn_debounce.
package tick_pkg;

    typedef enum logic [1:0] {
        LO_STABLE = 2'd0,
        LO_WAIT   = 2'd1,
        HI_STABLE = 2'd2,
        HI_WAIT   = 2'd3
    } db_state_t;

    // Phase increment contributed by button i.
    function automatic int step_of(input int i, input int accel_log2);
        return int'(32'd1 << (accel_log2 * (i + 1)));
    endfunction

    // Width of a counter that holds 0..period-1.
    function automatic int cnt_width(input int period);
        return (period < 2) ? 1 : $clog2(period);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-FF synchronizer followed by a debounce FSM when
// TICK_DEBOUNCE_EN is defined, otherwise the synchronizer output directly.
module btn_debounce
    import tick_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic level_next
);

    logic sync_a;
    logic sync_b;

    // Two-stage synchronizer for the asynchronous button input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

`ifdef TICK_DEBOUNCE_EN
    // The entry cycle counts toward the stable time, so DEBOUNCE_CYC must be >= 2.
    localparam int TW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [TW-1:0] LAST = TW'(DEBOUNCE_CYC - 1);

    db_state_t     state;
    db_state_t     state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [TW-1:0] timer_inc;
    logic          press_next;

    assign timer_inc = timer + TW'(1);

    // Debounce next-state, timer and level/press decode.
    always_comb begin
        state_next = state;
        timer_next = timer;
        level_next = level;
        press_next = 1'b0;
        case (state)
            LO_STABLE: begin
                if (sync_b) begin
                    state_next = LO_WAIT;
                    timer_next = '0;
                end else begin
                    state_next = LO_STABLE;
                end
            end
            LO_WAIT: begin
                if (!sync_b) begin
                    state_next = LO_STABLE;
                end else if (timer_inc == LAST) begin
                    state_next = HI_STABLE;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    timer_next = timer_inc;
                end
            end
            HI_STABLE: begin
                if (!sync_b) begin
                    state_next = HI_WAIT;
                    timer_next = '0;
                end else begin
                    state_next = HI_STABLE;
                end
            end
            HI_WAIT: begin
                if (sync_b) begin
                    state_next = HI_STABLE;
                end else if (timer_inc == LAST) begin
                    state_next = LO_STABLE;
                    level_next = 1'b0;
                end else begin
                    timer_next = timer_inc;
                end
            end
            default: begin
                state_next = LO_STABLE;
                timer_next = '0;
                level_next = 1'b0;
            end
        endcase
    end

    // Debounce state, timer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LO_STABLE;
            timer <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            level <= level_next;
            press <= press_next;
        end
    end
`else
    assign level      = sync_b;
    assign level_next = sync_a;

    // Rising-edge detect aligned with the synchronizer output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press <= 1'b0;
        end else begin
            press <= sync_a & ~sync_b;
        end
    end
`endif

endmodule

// File: rtl/tick_prescaler.sv
// Time base: tick pulse, tick square wave, scan strobe and button acceleration.
// Define TICK_DEBOUNCE_EN to build the button debounce FSMs.
module tick_prescaler
    import tick_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int TICK_HZ       = 1,
    parameter int NUM_BTN       = 3,
    parameter int ACCEL_LOG2    = 3,
    parameter int DEBOUNCE_CYC  = 500_000,
    parameter int SCAN_DIV_LOG2 = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_BTN-1:0] btn,
    output logic               tick,
    output logic               tick_sq,
    output logic               scan_stb,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               accel_active
);

    localparam int CW = cnt_width(CLK_HZ / TICK_HZ);
    localparam logic [CW:0] PERIOD = (CW+1)'(CLK_HZ / TICK_HZ);

    logic [CW-1:0]            cnt;
    logic [CW:0]              step;
    logic [CW:0]              sum;
    logic [SCAN_DIV_LOG2-1:0] scan_cnt;
    logic [NUM_BTN-1:0]       level_next;
    int                       step_int;

    // Highest-index pressed button selects the step, clamped to one period.
    always_comb begin
        step_int = 1;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_level[i]) begin
                step_int = step_of(i, ACCEL_LOG2);
            end else begin
                step_int = step_int;
            end
        end
        if (step_int > int'(PERIOD)) begin
            step = PERIOD;
        end else begin
            step = (CW+1)'(step_int);
        end
    end

    assign sum = {1'b0, cnt} + step;

    // Phase accumulator; the remainder is kept on wrap so rates never drift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            tick    <= 1'b0;
            tick_sq <= 1'b0;
        end else if (en) begin
            if (sum >= PERIOD) begin
                cnt     <= CW'(sum - PERIOD);
                tick    <= 1'b1;
                tick_sq <= ~tick_sq;
            end else begin
                cnt     <= sum[CW-1:0];
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

    // Free-running scan divider; strobe lands in the cycle the counter reads 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_stb <= 1'b0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_DIV_LOG2'(1);
            scan_stb <= &scan_cnt;
        end
    end

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_db (
            .clk        (clk),
            .rst        (rst),
            .raw        (btn[g]),
            .level      (btn_level[g]),
            .press      (btn_press[g]),
            .level_next (level_next[g])
        );
    end

    // Registered alongside the debounced levels so it never lags them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accel_active <= 1'b0;
        end else begin
            accel_active <= |level_next;
        end
    end

endmodule

// File: doc/tick_prescaler.md
# tick_prescaler

Parametrised time-base generator for the clock/display designs. It divides the board clock into a 1-per-period `tick` pulse, a `tick_sq` square wave and a free-running display-scan strobe. Debounced pushbuttons accelerate the tick rate for time-setting, and an enable input freezes the time base. It sits between the board pins and the clock/7-segment logic and replaces hand-written divider code in top levels.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency
- `TICK_HZ`, 1, nominal tick rate; `PERIOD = CLK_HZ/TICK_HZ` (integer, ≥2)
- `NUM_BTN`, 3, number of acceleration buttons (1..4)
- `ACCEL_LOG2`, 3, button i adds `STEP_i = 1 << (ACCEL_LOG2*(i+1))` per cycle
- `DEBOUNCE_CYC`, 500_000, stable cycles required to accept a button change
- `SCAN_DIV_LOG2`, 16, scan strobe every `2^SCAN_DIV_LOG2` cycles
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  1 = time base runs; 0 = phase counter frozen
- `btn`  in  NUM_BTN  raw asynchronous pushbuttons, active-high
- `tick`  out  1  one-cycle pulse per period
- `tick_sq`  out  1  toggles on every `tick`
- `scan_stb`  out  1  one-cycle scan strobe
- `btn_level`  out  NUM_BTN  debounced button levels
- `btn_press`  out  NUM_BTN  one-cycle pulse on debounced rising edge
- `accel_active`  out  1  any `btn_level` bit set

## Operation
- Reset: phase counter, scan counter, `tick`, `tick_sq`, `scan_stb`, `btn_level`, `btn_press` and `accel_active` are all 0. Debouncers enter `LO_STABLE`.
- Step select: the highest-index set bit of `btn_level` gives `STEP_i`. With no bit set, step = 1. Step is clamped to `PERIOD`.
- Phase counter `cnt`, width `$clog2(PERIOD)`. When `en`=1 it computes `sum = cnt + step` at `$clog2(PERIOD)+1` bits or wider:
  - `sum ≥ PERIOD`: `cnt <= sum - PERIOD`, `tick` = 1, `tick_sq` toggles.
  - Otherwise `cnt <= sum`, `tick` = 0.
  - The remainder is kept on wrap, so there is no modulo drift. At most one tick per cycle.
- `en`=0: `cnt` holds and `tick` = 0. When `en` returns, counting resumes from the held phase.
- Scan counter: `SCAN_DIV_LOG2` bits, free-running and independent of `en`. `scan_stb` = 1 in the cycle after the counter wraps to 0.
- Per-button path: a 2-FF synchronizer, then a debounce FSM.
  - FSM states: `LO_STABLE`, `LO_WAIT`, `HI_STABLE`, `HI_WAIT`.
  - `LO_STABLE`: a synchronized 1 moves to `LO_WAIT` and clears the timer.
  - `LO_WAIT`: a 0 returns to `LO_STABLE`. When the timer reaches `DEBOUNCE_CYC-1`, go to `HI_STABLE`, set the level to 1 and pulse `btn_press`.
  - `HI_STABLE` and `HI_WAIT` mirror this for release; release produces no pulse.
- `accel_active` = OR of `btn_level`, registered together with it.

## Timing
- `tick`, `tick_sq` and `scan_stb` are registered. `tick` is asserted in the cycle after the wrapping addition is evaluated.
- Button latency from a clean raw edge to the `btn_level` change is 2 + `DEBOUNCE_CYC` cycles. `btn_press` is coincident with the `btn_level` rise.
- A `btn_level` change affects the step used in the following cycle.
- Simultaneous buttons: the highest index wins, with no blending.
- `rst` mid-period or mid-debounce clears everything immediately. The first tick after release arrives `PERIOD` cycles later with no buttons pressed.

## Configuration
- `TICK_DEBOUNCE_EN` defined: debounce FSMs are instantiated as above.
- Not defined: `btn_level` = 2-FF synchronizer output, so latency is 2 cycles. `btn_press` is an edge detect on that output. The FSMs and timers are not built.

## Structure
- Shared package `tick_pkg`:
  - debounce state enum
  - `step_of(i, ACCEL_LOG2)` function
  - `PERIOD` width helper
- Sub-module `btn_debounce`, one per button: synchronizer, FSM and timer, producing `level`/`press`. It is instantiated through a generate loop.

## Test plan
Parameters for all scenarios: CLK_HZ=100, TICK_HZ=10 (PERIOD=10), ACCEL_LOG2=1 (steps 2/4/8), DEBOUNCE_CYC=4, SCAN_DIV_LOG2=3.
- Release `rst`, `en`=1, no buttons -> `tick` every 10 cycles; `tick_sq` toggles on each; `scan_stb` every 8 cycles.
- Drop `en` for 25 cycles at `cnt`=6 -> no `tick`, `cnt` stays 6; the first tick comes 4 cycles after `en` returns.
- Hold `btn[0]` clean -> `btn_level[0]` and a single `btn_press[0]` 6 cycles later; ticks then every 5 cycles. Release -> level falls 6 cycles later, no press pulse.
- Toggle `btn[1]` every 2 cycles for 20 cycles, then hold 1 -> no level change during the bounce; level rises 6 cycles after the last edge.
- Hold `btn[0]` and `btn[2]` -> step 8; `cnt` sequence 0,8,6,4,2,0 with ticks on the 4 wraps (on the updates producing 6,4,2,0); `accel_active`=1.
- Assert `rst` during `LO_WAIT` with `tick_sq`=1 -> all outputs 0 immediately; no `btn_press` after release.
